// File: rtl/led_tick_ctrl.sv
// led_tick_ctrl: step-rate prescaler with debounced run/blank and speed pushbuttons.
module led_tick_ctrl #(
  parameter int STEP_DIV  = 12_500_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 24,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run_n,
  input  logic       btn_speed_n,
  output logic       step,
  output logic       state_ctrl,
  output logic [1:0] speed
);
  typedef enum logic {RUN = 1'b0, BLANK = 1'b1} state_t;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES);
  state_t state_q, state_d;
  logic [1:0] sy1_q, sy2_q, stb_q, stb_d, hit, press;
  logic [DB_W-1:0] db_q [2];
  logic [DB_W-1:0] db_d [2];
  logic [1:0] speed_q, speed_d;
  logic [CNT_W-1:0] per, cnt_q, cnt_d;
  logic step_q, step_d, run_ev, spd_ev, clr, wrap;
  // bit 0 is the run button, bit 1 the speed button
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = sy2_q[i] != stb_q[i] && db_q[i] == DB_MAX;
      db_d[i] = sy2_q[i] != stb_q[i] && !hit[i] ? db_q[i] + 1'b1 : '0;
      stb_d[i] = hit[i] ? sy2_q[i] : stb_q[i];
      press[i] = hit[i] & ~sy2_q[i];
    end
  end
  assign run_ev = press[0];
  assign spd_ev = press[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else state_q <= state_d;
  end
  always_comb state_d = run_ev ? (state_q == RUN ? BLANK : RUN) : state_q;
  always_comb state_ctrl = state_q == RUN;
  // any button event restarts the period so the first step lands a full period later
  always_comb begin
    speed_d = speed_q + {1'b0, spd_ev};
    per = CNT_W'(STEP_DIV) >> speed_q;
    clr = spd_ev || run_ev || state_q == BLANK;
    wrap = cnt_q == per - 1'b1;
    cnt_d = clr || wrap ? '0 : cnt_q + 1'b1;
    step_d = !clr && wrap;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy1_q <= '1;
      sy2_q <= '1;
      stb_q <= '1;
      db_q <= '{default: '0};
      speed_q <= '0;
      cnt_q <= '0;
      step_q <= 1'b0;
    end else begin
      sy1_q <= {btn_speed_n, btn_run_n};
      sy2_q <= sy1_q;
      stb_q <= stb_d;
      db_q <= db_d;
      speed_q <= speed_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
    end
  end
  assign step = step_q;
  assign speed = speed_q;
endmodule

// File: tb/tb_led_tick_ctrl.sv
// tb_led_tick_ctrl: directed bench with a queue of expected step edges for led_tick_ctrl.
module tb_led_tick_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run_n = 1'b1;
  logic btn_speed_n = 1'b1;
  logic step, state_ctrl;
  logic [1:0] speed;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  int q[$];
  int nxt = 0;
  int per = 16;
  int spd_m = 0;
  bit running = 1'b1;

  led_tick_ctrl #(.STEP_DIV(16), .DB_CYCLES(4), .CNT_W(8), .DB_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .btn_run_n(btn_run_n),
    .btn_speed_n(btn_speed_n),
    .step(step),
    .state_ctrl(state_ctrl),
    .speed(speed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // every step pulse must match the oldest expected step edge
  always @(posedge clk) begin
    int e;
    #1;
    if (step) begin
      e = -1;
      if (q.size() > 0) e = q.pop_front();
      chk("step_time", cyc, e);
    end
  end

  task automatic go(input int t);
    while (running && nxt <= t) begin
      q.push_back(nxt);
      nxt += per;
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input bit run, input bit spd, input int hold);
    int c, e;
    c = cyc;
    e = c + 7;
    if (run) btn_run_n = 1'b0;
    if (spd) btn_speed_n = 1'b0;
    go(e - 1);
    chk("state_pre", state_ctrl, running);
    chk("speed_pre", speed, spd_m);
    if (spd) spd_m = (spd_m + 1) % 4;
    if (run) running = !running;
    per = 16 >> spd_m;
    nxt = e + per;
    go(e);
    chk("state_post", state_ctrl, running);
    chk("speed_post", speed, spd_m);
    go(c + hold);
    btn_run_n = 1'b1;
    btn_speed_n = 1'b1;
    go(c + hold + 12);
    chk("state_release", state_ctrl, running);
    chk("speed_release", speed, spd_m);
    chk("missing_steps", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_state", state_ctrl, 1);
    chk("rst_speed", speed, 0);
    rst = 1'b0;
    nxt = cyc + 16;
    go(cyc + 100);
    chk("free_missing", q.size(), 0);
    chk("free_state", state_ctrl, 1);
    chk("free_speed", speed, 0);
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 20);
    for (int i = 0; i < 5; i++) begin
      btn_run_n = 1'b0;
      go(cyc + 3);
      btn_run_n = 1'b1;
      go(cyc + 3);
    end
    chk("glitch_state", state_ctrl, 1);
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b1, 10);
    press(1'b0, 1'b1, 20);
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_step", step, 0);
    chk("arst_state", state_ctrl, 1);
    chk("arst_speed", speed, 0);
    @(negedge clk);
    rst = 1'b0;
    running = 1'b1;
    spd_m = 0;
    per = 16;
    nxt = cyc + 16;
    go(cyc + 60);
    chk("post_rst_missing", q.size(), 0);
    press(1'b0, 1'b1, 1000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
